set_assoc_cache_ctrl: RTL and testbench
=======================================

Name: set_assoc_cache_ctrl

Overview:
Parametrised N-way set-associative cache controller, one word per line, sitting between the CPU load/store port and the main-memory model.
- Write-through, write-allocate.
- NRU (not-recently-used) replacement via per-way reference bits.
- Valid/ready handshakes on both CPU and memory sides, so memory latency is arbitrary.
- Hit/miss statistics counters.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width
WAYS, 4, associativity (power of two, 2..8)
SETS, 256, sets per way (power of two)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req_valid  in  1  CPU request present
cpu_req_ready  out  1  controller accepts request
cpu_req_we  in  1  1=write, 0=read
cpu_req_addr  in  ADDR_W  byte address (bits [1:0] ignored)
cpu_req_wdata  in  DATA_W  write data
cpu_rsp_valid  out  1  one-cycle response pulse
cpu_rsp_hit  out  1  request hit in cache
cpu_rsp_rdata  out  DATA_W  read data (0 for writes)
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  memory write
mem_req_addr  out  ADDR_W  word-aligned address
mem_req_wdata  out  DATA_W  memory write data
mem_rsp_valid  in  1  read data return
mem_rsp_rdata  in  DATA_W  read data
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter

Behaviour:
Address fields:
- IDX_W=log2(SETS).
- Index = addr[IDX_W+1:2].
- Tag = addr[ADDR_W-1:IDX_W+2].

Reset (async, rst_n low):
- State=IDLE.
- All valid and ref bits=0.
- All outputs 0; cpu_req_ready=0 while in reset.
- Counters=0.
- Tag/data arrays are not reset.
- Reset mid-transaction abandons it: no response; an outstanding memory request is dropped.

FSM states and transitions:
- IDLE:
  - cpu_req_ready=1.
  - On valid&ready, latch we/addr/wdata → LOOKUP.
- LOOKUP (1 cycle): compare the tag against all WAYS with valid=1.
  - Read hit: cpu_rsp_valid=1, hit=1, rdata=hit-way data; update ref; hit_count++ → IDLE.
  - Write hit: update data in hit way; update ref; hit_count++ → WR_MEM.
  - Miss: choose victim; miss_count++.
    - Write miss: install tag/data/valid in victim → WR_MEM.
    - Read miss: → RD_REQ.
- RD_REQ:
  - mem_req_valid=1, we=0, addr={addr[ADDR_W-1:2],2'b00}.
  - Hold until mem_req_ready → RD_WAIT.
- RD_WAIT: on mem_rsp_valid:
  - Fill victim (tag, data, valid=1, ref update).
  - cpu_rsp_valid=1, hit=0, rdata=mem_rsp_rdata.
  - → IDLE.
- WR_MEM:
  - mem_req_valid=1, we=1, wdata=latched wdata.
  - On mem_req_ready: cpu_rsp_valid=1, hit=lookup result, rdata=0 → IDLE.

Latency and handshake:
- Read hit: response 2 cycles after the accept edge.
- Writes and misses: bounded by memory handshake.
- One outstanding request; cpu_req_ready=0 outside IDLE.
- mem_req_* held stable while mem_req_valid=1 and mem_req_ready=0.

Victim selection:
- Lowest-index invalid way.
- Otherwise lowest-index way with ref=0.
- If all refs are 1, way 0.

Ref update on any access or fill:
- Set the ref of the accessed way.
- If this makes all WAYS refs 1 in that set, clear all others in the set.

Statistics:
- Counters saturate at all-ones; they never wrap.

Multiple-way match: cannot occur by construction. Verification asserts at most one hit way.

Decomposition:
Shared package cache_pkg holds:
- state enum (IDLE, LOOKUP, RD_REQ, RD_WAIT, WR_MEM)
- a clog2-based IDX_W/TAG_W function
- victim-select and ref-update functions

One natural sub-module: cache_way_array (per-way tag/data/valid/ref storage, index read port, single write port). It is instantiated WAYS times via generate. The FSM, compare, victim logic and counters stay in the top.

Test Plan:
1. Reset with rst_n=0 then 1. Read 0x40 → miss; mem read of 0x40 returns 111; rsp hit=0 rdata=111; miss_count=1. Read 0x40 again → hit=1 rdata=111, 2 cycles after accept; hit_count=1.
2. Write 0x440 data 222 (same set 16, empty way). Expect mem write 0x440/222 and rsp hit=0. Read 0x440 → hit=1 rdata=222.
3. Writes to 0x40, 0xC40, 0x1C40, 0x2C40 fill set 16 (4 ways). Read 0x40 and 0xC40 (refs set). Then write 0x840 data 5000 → victim is the lowest way with ref=0. Read 0x840 → hit rdata=5000. Read the evicted address → miss.
4. Stall mem_req_ready=0 for 5 cycles during RD_REQ. mem_req_* stay stable and cpu_req_ready=0; the response arrives only after ready+rsp.
5. Drop rst_n mid RD_WAIT. Expect no cpu_rsp_valid and all valid cleared: a subsequent read 0x40 misses.
6. Preload hit_count to saturation (2^CNT_W-1 hits, CNT_W=4 build) then one more hit → hit_count stays at 15.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative cache controller.
// Way vectors use a fixed 8-bit width so the helpers serve any WAYS.
package cache_pkg;
  localparam int MAX_WAYS = 8;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, RD_REQ, RD_WAIT, WR_MEM
  } state_t;

  typedef logic [MAX_WAYS-1:0] wayvec_t;
  typedef logic [2:0] wayidx_t;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - $clog2(sets) - 2;
  endfunction

  function automatic wayidx_t victim_sel(
    input wayvec_t vld,
    input wayvec_t rb,
    input int ways
  );
    wayidx_t v;
    logic found;
    v = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_WAYS; i++)
      if (!found && i < ways && !vld[i]) begin
        v = wayidx_t'(i);
        found = 1'b1;
      end
    for (int i = 0; i < MAX_WAYS; i++)
      if (!found && i < ways && !rb[i]) begin
        v = wayidx_t'(i);
        found = 1'b1;
      end
    return v;
  endfunction

  // Saturated ref vector collapses to only the way just touched.
  function automatic wayvec_t ref_update(
    input wayvec_t rb,
    input wayidx_t way,
    input int ways
  );
    wayvec_t r, mask;
    mask = wayvec_t'((16'd1 << ways) - 16'd1);
    r = (rb | (wayvec_t'(1) << way)) & mask;
    if (r == mask) r = wayvec_t'(1) << way;
    return r;
  endfunction
endpackage

// File: rtl/cache_way_array.sv
// One cache way: tag/data storage plus resettable valid and ref bits.
// Reads are combinational on idx; writes land at the next clock edge.
module cache_way_array import cache_pkg::*; #(
  parameter int SETS   = 256,
  parameter int TAG_W  = 22,
  parameter int DATA_W = 32,
  parameter int IDX_W  = idx_w(SETS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_ref,
  input  logic              line_we,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ref_we,
  input  logic              ref_val
);
  logic [TAG_W-1:0]  tags [SETS];
  logic [DATA_W-1:0] data [SETS];
  logic [SETS-1:0]   valid;
  logic [SETS-1:0]   refb;

  always_ff @(posedge clk) begin
    if (line_we) begin
      tags[idx] <= wr_tag;
      data[idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      refb  <= '0;
    end else begin
      if (line_we) valid[idx] <= 1'b1;
      if (ref_we)  refb[idx]  <= ref_val;
    end
  end

  assign rd_tag   = tags[idx];
  assign rd_data  = data[idx];
  assign rd_valid = valid[idx];
  assign rd_ref   = refb[idx];
endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative write-through/write-allocate cache controller
// with NRU replacement and saturating hit/miss counters.
module set_assoc_cache_ctrl import cache_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAYS   = 4,
  parameter int SETS   = 256,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_rsp_valid,
  output logic              cpu_rsp_hit,
  output logic [DATA_W-1:0] cpu_rsp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, SETS);

  state_t state, nxt;
  logic              we_q, hit_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  wayidx_t           way_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WAYS-1:0]   vld, rb, hit_v, line_we, new_ref;
  logic [TAG_W-1:0]  rtag [WAYS];
  logic [DATA_W-1:0] rdat [WAYS];
  logic [DATA_W-1:0] hit_data, line_data;
  logic              hit_any, fill, ref_we;
  wayidx_t           hit_way, victim, acc_way;

  assign idx = addr_q[IDX_W+1:2];
  assign tag = addr_q[ADDR_W-1:IDX_W+2];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way_array #(
      .SETS(SETS), .TAG_W(TAG_W), .DATA_W(DATA_W)
    ) u_way (
      .clk      (clk),
      .rst_n    (rst_n),
      .idx      (idx),
      .rd_tag   (rtag[w]),
      .rd_data  (rdat[w]),
      .rd_valid (vld[w]),
      .rd_ref   (rb[w]),
      .line_we  (line_we[w]),
      .wr_tag   (tag),
      .wr_data  (line_data),
      .ref_we   (ref_we),
      .ref_val  (new_ref[w])
    );
    assign hit_v[w] = vld[w] && (rtag[w] == tag);
    assign line_we[w] = fill && (acc_way == wayidx_t'(w));
  end

  always_comb begin
    hit_any  = 1'b0;
    hit_way  = '0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++)
      if (hit_v[w]) begin
        hit_any  = 1'b1;
        hit_way  = wayidx_t'(w);
        hit_data = rdat[w];
      end
  end

  // LOOKUP touches the hit or victim way; RD_WAIT fills the latched way.
  assign victim  = victim_sel(wayvec_t'(vld), wayvec_t'(rb), WAYS);
  assign acc_way = (state == LOOKUP) ? (hit_any ? hit_way : victim) : way_q;
  assign new_ref = WAYS'(ref_update(wayvec_t'(rb), acc_way, WAYS));

  always_comb begin
    fill      = 1'b0;
    ref_we    = 1'b0;
    line_data = wdata_q;
    if (state == LOOKUP) begin
      fill   = we_q;
      ref_we = hit_any || we_q;
    end else if (state == RD_WAIT && mem_rsp_valid) begin
      fill      = 1'b1;
      ref_we    = 1'b1;
      line_data = mem_rsp_rdata;
    end
  end

  always_comb begin
    nxt           = state;
    cpu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    unique case (state)
      IDLE: begin
        cpu_req_ready = rst_n;
        if (cpu_req_valid) nxt = LOOKUP;
      end
      LOOKUP: begin
        if (we_q) nxt = WR_MEM;
        else      nxt = hit_any ? IDLE : RD_REQ;
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr_q & ~ADDR_W'(3);
        if (mem_req_ready) nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rsp_valid) nxt = IDLE;
      end
      WR_MEM: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = addr_q & ~ADDR_W'(3);
        mem_req_wdata = wdata_q;
        if (mem_req_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      hit_q         <= 1'b0;
      way_q         <= '0;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_hit   <= 1'b0;
      cpu_rsp_rdata <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      state         <= nxt;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_hit   <= 1'b0;
      cpu_rsp_rdata <= '0;
      if (state == IDLE && cpu_req_valid) begin
        we_q    <= cpu_req_we;
        addr_q  <= cpu_req_addr;
        wdata_q <= cpu_req_wdata;
      end
      if (state == LOOKUP) begin
        hit_q <= hit_any;
        way_q <= acc_way;
        if (hit_any) begin
          if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
          if (!we_q) begin
            cpu_rsp_valid <= 1'b1;
            cpu_rsp_hit   <= 1'b1;
            cpu_rsp_rdata <= hit_data;
          end
        end else if (miss_count != '1) begin
          miss_count <= miss_count + CNT_W'(1);
        end
      end
      if (state == RD_WAIT && mem_rsp_valid) begin
        cpu_rsp_valid <= 1'b1;
        cpu_rsp_rdata <= mem_rsp_rdata;
      end
      if (state == WR_MEM && mem_req_ready) begin
        cpu_rsp_valid <= 1'b1;
        cpu_rsp_hit   <= hit_q;
      end
    end
  end
endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Randomised bench for set_assoc_cache_ctrl against a per-set array
// model of valid/tag/data/ref state plus a sparse word memory.
module tb_set_assoc_cache_ctrl;
  import cache_pkg::*;
  localparam int AW = 32, DW = 32, WAYS = 4, SETS = 256, CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [AW-1:0] cpu_req_addr;
  logic [DW-1:0] cpu_req_wdata;
  logic cpu_rsp_valid, cpu_rsp_hit;
  logic [DW-1:0] cpu_rsp_rdata;
  logic mem_req_valid, mem_req_ready, mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic mem_rsp_valid;
  logic [DW-1:0] mem_rsp_rdata;
  logic [CW-1:0] hit_count, miss_count;

  always #5 clk = ~clk;

  set_assoc_cache_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .WAYS(WAYS), .SETS(SETS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_hit(cpu_rsp_hit),
    .cpu_rsp_rdata(cpu_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int checks = 0;
  int fails = 0;

  bit          mv [SETS][WAYS];
  bit          mr [SETS][WAYS];
  logic [21:0] mt [SETS][WAYS];
  logic [31:0] md [SETS][WAYS];
  logic [31:0] mem [int unsigned];
  int hits_m, miss_m;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && dut.state == LOOKUP)
      chk("onehot_hit", 32'($onehot0(dut.hit_v)), 32'd1);

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        mv[s][w] = 1'b0;
        mr[s][w] = 1'b0;
      end
    hits_m = 0;
    miss_m = 0;
  endtask

  function automatic int pick_victim(input int s);
    int v;
    v = -1;
    for (int w = 0; w < WAYS; w++) if (v < 0 && !mv[s][w]) v = w;
    for (int w = 0; w < WAYS; w++) if (v < 0 && !mr[s][w]) v = w;
    if (v < 0) v = 0;
    return v;
  endfunction

  task automatic touch(input int s, input int w);
    bit all;
    mr[s][w] = 1'b1;
    all = 1'b1;
    for (int i = 0; i < WAYS; i++) if (!mr[s][i]) all = 1'b0;
    if (all)
      for (int i = 0; i < WAYS; i++) mr[s][i] = (i == w);
  endtask

  task automatic do_req(input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input int stall,
                        input int rdly);
    int s, hw, vw, cyc, st, rd;
    logic [21:0] tg;
    bit ehit, emem, mseen, macc, rsent, got, mwe;
    logic [31:0] erd, mwa, mwd;
    s  = int'(a[9:2]);
    tg = a[31:10];
    hw = -1;
    for (int w = 0; w < WAYS; w++)
      if (mv[s][w] && mt[s][w] == tg) hw = w;
    ehit = (hw >= 0);
    emem = we || !ehit;
    vw = ehit ? hw : pick_victim(s);
    if (!mem.exists(a >> 2)) mem[a >> 2] = $urandom;
    if (we) begin
      erd = '0;
      md[s][vw] = wd;
      mem[a >> 2] = wd;
    end else begin
      erd = ehit ? md[s][vw] : mem[a >> 2];
    end
    if (!ehit) begin
      mt[s][vw] = tg;
      mv[s][vw] = 1'b1;
      if (!we) md[s][vw] = erd;
    end
    touch(s, vw);
    if (ehit) begin
      if (hits_m < SAT) hits_m++;
    end else if (miss_m < SAT) miss_m++;

    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = a;
    cpu_req_wdata = wd;
    cyc = 0;
    while (!cpu_req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("accept", 32'(cpu_req_ready), 32'd1);
    if (!cpu_req_ready) begin
      cpu_req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = $urandom;
    cpu_req_wdata = $urandom;

    cyc = 0; st = stall; rd = rdly;
    mseen = 0; macc = 0; rsent = 0; got = 0; mwe = 0;
    mwa = '0; mwd = '0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = $urandom;
      if (cpu_rsp_valid) begin
        got = 1;
        chk("rsp_hit", 32'(cpu_rsp_hit), 32'(ehit));
        chk("rsp_rdata", cpu_rsp_rdata, erd);
        if (ehit && !we) chk("hit_latency", 32'(cyc), 32'd2);
      end else if (mem_req_valid && !macc) begin
        if (!mseen) begin
          mseen = 1;
          mwe = mem_req_we;
          mwa = mem_req_addr;
          mwd = mem_req_wdata;
        end else begin
          chk("mem_addr_stable", mem_req_addr, mwa);
          chk("mem_wdata_stable", mem_req_wdata, mwd);
          chk("mem_we_stable", 32'(mem_req_we), 32'(mwe));
        end
        chk("busy_not_ready", 32'(cpu_req_ready), 32'd0);
        if (st > 0) st--;
        else begin
          mem_req_ready = 1'b1;
          macc = 1;
        end
      end else if (macc && !mwe && !rsent) begin
        if (rd > 0) rd--;
        else begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = mem[a >> 2];
          rsent = 1;
        end
      end
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    chk("rsp_seen", 32'(got), 32'd1);
    chk("mem_used", 32'(mseen), 32'(emem));
    if (mseen) begin
      chk("mem_we", 32'(mwe), 32'(we));
      chk("mem_addr", mwa, a & ~32'd3);
      if (we) chk("mem_wdata", mwd, wd);
    end
    chk("hit_count", 32'(hit_count), 32'(hits_m));
    chk("miss_count", 32'(miss_count), 32'(miss_m));
  endtask

  logic [31:0] t3 [10];
  logic [31:0] ra;
  int cyc;

  initial begin
    rst_n = 1'b0;
    cpu_req_valid = 1'b0; cpu_req_we = 1'b0;
    cpu_req_addr = '0; cpu_req_wdata = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cpu_req_ready), 32'd0);
    chk("rst_rsp", 32'(cpu_rsp_valid), 32'd0);
    chk("rst_mreq", 32'(mem_req_valid), 32'd0);
    chk("rst_hits", 32'(hit_count), 32'd0);
    chk("rst_miss", 32'(miss_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(cpu_req_ready), 32'd1);

    mem[32'h40 >> 2] = 32'd111;
    do_req(0, 32'h40, 0, 0, 0);
    do_req(0, 32'h40, 0, 0, 0);
    do_req(1, 32'h440, 32'd222, 1, 0);
    do_req(0, 32'h440, 0, 0, 0);

    t3 = '{32'h40, 32'hC40, 32'h1C40, 32'h2C40, 32'h840,
           32'h440, 32'h40, 32'hC40, 32'h1C40, 32'h2C40};
    for (int i = 0; i < 4; i++) do_req(1, t3[i], 32'd300 + 32'(i), 0, 0);
    do_req(0, 32'h40, 0, 0, 0);
    do_req(0, 32'hC40, 0, 0, 0);
    do_req(1, 32'h840, 32'd5000, 0, 0);
    for (int i = 4; i < 10; i++) do_req(0, t3[i], 0, 0, 1);

    do_req(0, 32'h3040, 0, 5, 2);

    for (int n = 0; n < 300; n++) begin
      ra = (32'($urandom_range(0, 5)) << 10)
         | (32'($urandom_range(0, 2) == 0 ? 16 :
                $urandom_range(0, 1) == 0 ? 17 : 200) << 2)
         | 32'($urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), ra, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h5040;
    cyc = 0;
    while (!cpu_req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    cyc = 0;
    while (!mem_req_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5_memreq", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_rsp", 32'(cpu_rsp_valid), 32'd0);
      chk("t5_ready0", 32'(cpu_req_ready), 32'd0);
      chk("t5_mreq0", 32'(mem_req_valid), 32'd0);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      chk("t5_no_rsp_after", 32'(cpu_rsp_valid), 32'd0);
    end
    chk("t5_hits0", 32'(hit_count), 32'd0);
    chk("t5_miss0", 32'(miss_count), 32'd0);
    do_req(0, 32'h40, 0, 0, 1);

    for (int i = 0; i < SAT + 1; i++) do_req(0, 32'h40, 0, 0, 0);
    chk("hit_sat", 32'(hit_count), 32'(SAT));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
